// File: rtl/fsm_seq_detector.sv
// fsm_seq_detector: serial "01" detector with side-by-side Moore and Mealy flags
module fsm_seq_detector (
  input  logic clk,
  input  logic reset,
  input  logic in_seq,
  output logic moore_Y,
  output logic mealy_Y
);
  typedef enum logic [1:0] {M_S0 = 2'b00, M_S1 = 2'b01, M_S2 = 2'b10} m_state_t;
  typedef enum logic {A_S0 = 1'b0, A_S1 = 1'b1} a_state_t;
  m_state_t m_state, m_next;
  a_state_t a_state, a_next;
  // Moore state register, cleared the moment reset falls
  always_ff @(posedge clk or negedge reset)
    if (!reset) m_state <= M_S0;
    else m_state <= m_next;
  // Mealy state register, kept separate so the two flavours never interact
  always_ff @(posedge clk or negedge reset)
    if (!reset) a_state <= A_S0;
    else a_state <= a_next;
  // Moore next state and flag; the unused 2'b11 encoding falls back to idle
  always_comb begin
    m_next = M_S0;
    if (m_state inside {M_S0, M_S1, M_S2})
      m_next = in_seq ? ((m_state == M_S1) ? M_S2 : M_S0) : M_S1;
    moore_Y = (m_state == M_S2);
  end
  // Mealy next state and flag; flag follows in_seq within the cycle and is masked by reset
  always_comb begin
    a_next = in_seq ? A_S0 : A_S1;
    mealy_Y = (a_state == A_S1) && in_seq && reset;
  end
endmodule

// File: tb/tb_fsm_seq_detector.sv
// tb_fsm_seq_detector: scoreboard bench for the "01" Moore/Mealy detector
module tb_fsm_seq_detector;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_seq = 1'b0;
  logic moore_Y, mealy_Y;
  int checks = 0;
  int errors = 0;
  int tag = 0;

  typedef struct {
    int   tag;
    int   idx;
    logic m;
    logic o;
  } exp_t;
  exp_t exp_q[$];

  fsm_seq_detector dut (
    .clk(clk),
    .reset(reset),
    .in_seq(in_seq),
    .moore_Y(moore_Y),
    .mealy_Y(mealy_Y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // One character per clock cycle: b is the bit driven during that cycle, m the
  // expected mealy_Y in that cycle, o the expected moore_Y in that cycle.
  task automatic run(input string b, input string m, input string o);
    exp_t e;
    tag++;
    for (int i = 0; i < b.len(); i++) begin
      @(negedge clk);
      in_seq = (b[i] == "1");
      e.tag = tag;
      e.idx = i;
      e.m = (m[i] == "1");
      e.o = (o[i] == "1");
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs are settled mid low-phase, after the driver has pushed its expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mealy_Y !== e.m) begin
          errors++;
          $display("FAIL vec%0d[%0d] mealy_Y: got %b, expected %b", e.tag, e.idx, mealy_Y, e.m);
        end
        checks++;
        if (moore_Y !== e.o) begin
          errors++;
          $display("FAIL vec%0d[%0d] moore_Y: got %b, expected %b", e.tag, e.idx, moore_Y, e.o);
        end
      end
    end
  end

  initial begin
    // held in reset while in_seq toggles: both flags stay low
    run("0101", "0000", "0000");
    @(negedge clk);
    reset = 1'b1;
    // first sampled 1 after release is not a hit
    run("1", "0", "0");
    // main sequence 0,1,0,0,1,1,0,1,1,1 plus one trailing 1 to observe the last moore cycle
    run("01001101111", "01001001000", "00100100100");
    // overlapping matches
    run("0101011", "0101010", "0010101");
    // long zero run gives a single hit
    run("000011", "000010", "000001");
    // all ones never hit
    run("1111", "0000", "0000");
    // reset pulse while moore_Y is high clears it without a clock edge
    run("01", "01", "00");
    @(negedge clk);
    in_seq = 1'b1;
    #1;
    chk("pre_reset moore_Y", moore_Y, 1'b1);
    reset = 1'b0;
    #1;
    chk("async moore_Y", moore_Y, 1'b0);
    chk("async mealy_Y", mealy_Y, 1'b0);
    #1;
    reset = 1'b1;
    // reset pulse after a 0: the partial pattern is dropped
    run("0", "0", "0");
    @(negedge clk);
    in_seq = 1'b1;
    #1;
    chk("pre_reset mealy_Y", mealy_Y, 1'b1);
    reset = 1'b0;
    #1;
    chk("in_reset mealy_Y", mealy_Y, 1'b0);
    chk("in_reset moore_Y", moore_Y, 1'b0);
    #1;
    reset = 1'b1;
    // the 1 sampled across the pulse gives no hit; detection then recovers
    run("10011", "00010", "00001");
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #3;
    chk("scoreboard drained", exp_q.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
